// File: rtl/vdp_cpu_vram_port.sv
// vdp_cpu_vram_port: CPU #98/#99 port decoder issuing toggle handshakes to the VRAM arbiter
// and holding the read-ahead byte returned by the arbiter.
module vdp_cpu_vram_port (
    input  logic        CLK21M,
    input  logic        RESET,
    input  logic [1:0]  DOTSTATE,
    input  logic        cpu_req,
    input  logic        cpu_wrt,
    input  logic        cpu_port,
    input  logic [7:0]  cpu_dbo,
    input  logic [7:0]  status_in,
    input  logic [2:0]  reg_r14,
    input  logic [7:0]  PRAMDBI_8,
    input  logic        VDPVRAMWRACK,
    input  logic        VDPVRAMRDACK,
    input  logic        VDPVRAMADDRSETACK,
    input  logic        VDPVRAMREADINGR,
    output logic [7:0]  cpu_dbi,
    output logic        cpu_wait,
    output logic [7:0]  VDPVRAMACCESSDATA,
    output logic [17:0] VDPVRAMACCESSADDRTMP,
    output logic        VDPVRAMWRREQ,
    output logic        VDPVRAMRDREQ,
    output logic        VDPVRAMADDRSETREQ,
    output logic        VDPVRAMREADINGA,
    output logic        reg_wr_stb,
    output logic [5:0]  reg_wr_num,
    output logic [7:0]  reg_wr_data
);
    logic       second;
    logic [7:0] low_byte;
    logic [7:0] read_ahead;
    logic       accept;
    logic       reading;

    assign reading  = VDPVRAMREADINGR != VDPVRAMREADINGA;
    assign cpu_wait = (VDPVRAMWRREQ != VDPVRAMWRACK) | (VDPVRAMRDREQ != VDPVRAMRDACK) |
                      (VDPVRAMADDRSETREQ != VDPVRAMADDRSETACK) | reading;
    assign accept   = cpu_req & ~cpu_wait;

    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            second               <= 1'b0;
            low_byte             <= 8'd0;
            read_ahead           <= 8'd0;
            cpu_dbi              <= 8'd0;
            VDPVRAMACCESSDATA    <= 8'd0;
            VDPVRAMACCESSADDRTMP <= 18'd0;
            VDPVRAMWRREQ         <= 1'b0;
            VDPVRAMRDREQ         <= 1'b0;
            VDPVRAMADDRSETREQ    <= 1'b0;
            VDPVRAMREADINGA      <= 1'b0;
            reg_wr_stb           <= 1'b0;
            reg_wr_num           <= 6'd0;
            reg_wr_data          <= 8'd0;
        end else begin
            reg_wr_stb <= 1'b0;
            if (reading && DOTSTATE == 2'b01) begin
                read_ahead      <= PRAMDBI_8;
                VDPVRAMREADINGA <= VDPVRAMREADINGR;
            end
            if (accept) begin
                if (!cpu_port) begin
                    second <= 1'b0;
                    if (cpu_wrt) begin
                        VDPVRAMACCESSDATA <= cpu_dbo;
                        VDPVRAMWRREQ      <= ~VDPVRAMWRREQ;
                    end else begin
                        cpu_dbi      <= read_ahead;
                        VDPVRAMRDREQ <= ~VDPVRAMRDREQ;
                    end
                end else if (!cpu_wrt) begin
                    second  <= 1'b0;
                    cpu_dbi <= status_in;
                end else if (!second) begin
                    low_byte <= cpu_dbo;
                    second   <= 1'b1;
                end else begin
                    second <= 1'b0;
                    if (cpu_dbo[7]) begin
                        reg_wr_stb  <= 1'b1;
                        reg_wr_num  <= cpu_dbo[5:0];
                        reg_wr_data <= low_byte;
                    end else begin
                        // read setup also prefetches the first byte
                        VDPVRAMACCESSADDRTMP <= {1'b0, reg_r14, cpu_dbo[5:0], low_byte};
                        VDPVRAMADDRSETREQ    <= ~VDPVRAMADDRSETREQ;
                        VDPVRAMRDREQ         <= VDPVRAMRDREQ ^ ~cpu_dbo[6];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vdp_cpu_vram_port.sv
// tb_vdp_cpu_vram_port: directed and randomized checks of the CPU VRAM port against a
// transaction-count model, with the bench acting as the VRAM arbiter.
module tb_vdp_cpu_vram_port;
    logic        CLK21M = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  DOTSTATE = 2'b00;
    logic        cpu_req = 1'b0, cpu_wrt = 1'b0, cpu_port = 1'b0;
    logic [7:0]  cpu_dbo = 8'd0, status_in = 8'd0, PRAMDBI_8 = 8'd0;
    logic [2:0]  reg_r14 = 3'd0;
    logic        VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR;
    logic [7:0]  cpu_dbi, VDPVRAMACCESSDATA, reg_wr_data;
    logic        cpu_wait, VDPVRAMWRREQ, VDPVRAMRDREQ, VDPVRAMADDRSETREQ, VDPVRAMREADINGA, reg_wr_stb;
    logic [17:0] VDPVRAMACCESSADDRTMP;
    logic [5:0]  reg_wr_num;

    // arbiter side: counts of acknowledged requests and of read-data deliveries
    int a_wr = 0, a_rd = 0, a_as = 0, r_rd = 0;
    bit auto_ack = 0;
    logic [7:0] pram_hold = 8'd0;
    int dot_k = 0;

    // model: counts of issued requests and of captured read-data deliveries
    int n_wr = 0, n_rd = 0, n_as = 0, n_ra = 0;
    logic        m_second = 0, m_stb = 0;
    logic [7:0]  m_low = 0, m_ra = 0, m_data = 0, m_dbi = 0, m_rdata = 0;
    logic [5:0]  m_num = 0;
    logic [17:0] m_addr = 0;

    int checks = 0, failures = 0;

    assign VDPVRAMWRACK      = a_wr[0];
    assign VDPVRAMRDACK      = a_rd[0];
    assign VDPVRAMADDRSETACK = a_as[0];
    assign VDPVRAMREADINGR   = r_rd[0];

    vdp_cpu_vram_port dut (
        .CLK21M(CLK21M), .RESET(RESET), .DOTSTATE(DOTSTATE), .cpu_req(cpu_req), .cpu_wrt(cpu_wrt),
        .cpu_port(cpu_port), .cpu_dbo(cpu_dbo), .status_in(status_in), .reg_r14(reg_r14),
        .PRAMDBI_8(PRAMDBI_8), .VDPVRAMWRACK(VDPVRAMWRACK), .VDPVRAMRDACK(VDPVRAMRDACK),
        .VDPVRAMADDRSETACK(VDPVRAMADDRSETACK), .VDPVRAMREADINGR(VDPVRAMREADINGR),
        .cpu_dbi(cpu_dbi), .cpu_wait(cpu_wait), .VDPVRAMACCESSDATA(VDPVRAMACCESSDATA),
        .VDPVRAMACCESSADDRTMP(VDPVRAMACCESSADDRTMP), .VDPVRAMWRREQ(VDPVRAMWRREQ),
        .VDPVRAMRDREQ(VDPVRAMRDREQ), .VDPVRAMADDRSETREQ(VDPVRAMADDRSETREQ),
        .VDPVRAMREADINGA(VDPVRAMREADINGA), .reg_wr_stb(reg_wr_stb), .reg_wr_num(reg_wr_num),
        .reg_wr_data(reg_wr_data)
    );

    always #5 CLK21M = ~CLK21M;

    function automatic bit m_wait();
        return n_wr != a_wr || n_rd != a_rd || n_as != a_as || r_rd != n_ra;
    endfunction

    function automatic logic [1:0] dot_of(input int k);
        case (k % 4)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            n_wr <= 0; n_rd <= 0; n_as <= 0; n_ra <= 0;
            m_second <= 0; m_stb <= 0; m_low <= 0; m_ra <= 0; m_data <= 0;
            m_dbi <= 0; m_rdata <= 0; m_num <= 0; m_addr <= 0;
        end else begin
            m_stb <= 1'b0;
            if (r_rd != n_ra && DOTSTATE == 2'b01) begin
                m_ra <= PRAMDBI_8;
                n_ra <= r_rd;
            end
            if (cpu_req && !m_wait()) begin
                if (!cpu_port) begin
                    m_second <= 1'b0;
                    if (cpu_wrt) begin
                        m_data <= cpu_dbo;
                        n_wr <= n_wr + 1;
                    end else begin
                        m_dbi <= m_ra;
                        n_rd <= n_rd + 1;
                    end
                end else if (!cpu_wrt) begin
                    m_second <= 1'b0;
                    m_dbi <= status_in;
                end else if (!m_second) begin
                    m_low <= cpu_dbo;
                    m_second <= 1'b1;
                end else begin
                    m_second <= 1'b0;
                    if (cpu_dbo[7]) begin
                        m_stb <= 1'b1;
                        m_num <= cpu_dbo[5:0];
                        m_rdata <= m_low;
                    end else begin
                        m_addr <= 18'(int'(reg_r14) * 16384 + int'(cpu_dbo[5:0]) * 256 + int'(m_low));
                        n_as <= n_as + 1;
                        if (!cpu_dbo[6]) n_rd <= n_rd + 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK21M) begin
        chk("cpu_wait", cpu_wait, m_wait());
        chk("wrreq", VDPVRAMWRREQ, n_wr[0]);
        chk("rdreq", VDPVRAMRDREQ, n_rd[0]);
        chk("addrsetreq", VDPVRAMADDRSETREQ, n_as[0]);
        chk("readinga", VDPVRAMREADINGA, n_ra[0]);
        chk("addrtmp", VDPVRAMACCESSADDRTMP, m_addr);
        chk("accessdata", VDPVRAMACCESSDATA, m_data);
        chk("cpu_dbi", cpu_dbi, m_dbi);
        chk("reg_wr_stb", reg_wr_stb, m_stb);
        chk("reg_wr_num", reg_wr_num, m_num);
        chk("reg_wr_data", reg_wr_data, m_rdata);
    end

    task automatic cyc(input logic req, input logic port, input logic wrt, input logic [7:0] d);
        @(negedge CLK21M);
        #1;
        if (auto_ack) begin
            if (n_wr != a_wr && $urandom_range(3) == 0) a_wr++;
            if (n_as != a_as && $urandom_range(3) == 0) a_as++;
            if (n_rd != a_rd && $urandom_range(3) == 0) begin
                a_rd++;
                r_rd++;
                pram_hold = 8'($urandom);
            end
        end
        PRAMDBI_8 = (r_rd != n_ra) ? pram_hold : 8'($urandom);
        DOTSTATE = dot_of(dot_k);
        dot_k++;
        cpu_req = req;
        cpu_port = port;
        cpu_wrt = wrt;
        cpu_dbo = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        idle(3);
        chk("rst_addrtmp", VDPVRAMACCESSADDRTMP, 18'h0);
        chk("rst_wait", cpu_wait, 1'b0);
        RESET = 1'b0;
        idle(2);
        // address setup for write: no prefetch
        reg_r14 = 3'd3;
        cyc(1, 1, 1, 8'h00);
        cyc(1, 1, 1, 8'h40);
        idle(1);
        chk("w_addr", VDPVRAMACCESSADDRTMP, 18'h0C000);
        chk("w_asreq", VDPVRAMADDRSETREQ, 1'b1);
        chk("w_rdreq", VDPVRAMRDREQ, 1'b0);
        chk("w_wait", cpu_wait, 1'b1);
        a_as++;
        idle(1);
        // address setup for read with prefetch
        reg_r14 = 3'd0;
        cyc(1, 1, 1, 8'h34);
        cyc(1, 1, 1, 8'h12);
        idle(1);
        chk("r_addr", VDPVRAMACCESSADDRTMP, 18'h01234);
        chk("r_asreq", VDPVRAMADDRSETREQ, 1'b0);
        chk("r_rdreq", VDPVRAMRDREQ, 1'b1);
        a_as++; a_rd++; r_rd++; pram_hold = 8'hA5;
        idle(6);
        chk("r_readinga", VDPVRAMREADINGA, 1'b1);
        chk("r_wait", cpu_wait, 1'b0);
        cyc(1, 0, 0, 8'h00);
        idle(1);
        chk("r_dbi", cpu_dbi, 8'hA5);
        chk("r_next_rdreq", VDPVRAMRDREQ, 1'b0);
        a_rd++; r_rd++; pram_hold = 8'h5A;
        idle(6);
        // register write
        cyc(1, 1, 1, 8'h07);
        cyc(1, 1, 1, 8'h81);
        idle(1);
        chk("reg_stb", reg_wr_stb, 1'b1);
        chk("reg_num", reg_wr_num, 6'd1);
        chk("reg_data", reg_wr_data, 8'h07);
        chk("reg_wait", cpu_wait, 1'b0);
        idle(1);
        chk("reg_stb_end", reg_wr_stb, 1'b0);
        // data write held off by missing ack
        cyc(1, 0, 1, 8'h55);
        idle(1);
        chk("dw_wait", cpu_wait, 1'b1);
        cyc(1, 0, 1, 8'hAA);
        idle(1);
        chk("dw_data", VDPVRAMACCESSDATA, 8'h55);
        chk("dw_wrreq", VDPVRAMWRREQ, 1'b1);
        a_wr++;
        #1;
        chk("dw_release", cpu_wait, 1'b0);
        // control read clears the byte phase
        status_in = 8'h3C;
        cyc(1, 1, 1, 8'h12);
        cyc(1, 1, 0, 8'h00);
        idle(1);
        chk("cr_dbi", cpu_dbi, 8'h3C);
        cyc(1, 1, 1, 8'h34);
        cyc(1, 1, 1, 8'h45);
        idle(1);
        chk("cr_phase_addr", VDPVRAMACCESSADDRTMP, 18'h00534);
        a_as++;
        idle(1);
        // reset during a pending write
        cyc(1, 0, 1, 8'h99);
        idle(1);
        chk("rs_wait_before", cpu_wait, 1'b1);
        RESET = 1'b1;
        a_wr = 0; a_rd = 0; a_as = 0; r_rd = 0;
        idle(2);
        chk("rs_wrreq", VDPVRAMWRREQ, 1'b0);
        chk("rs_data", VDPVRAMACCESSDATA, 8'h00);
        chk("rs_dbi", cpu_dbi, 8'h00);
        chk("rs_addr", VDPVRAMACCESSADDRTMP, 18'h0);
        RESET = 1'b0;
        idle(1);
        chk("rs_wait_after", cpu_wait, 1'b0);
        // randomized traffic with a randomly slow arbiter
        auto_ack = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(1) == 1) begin
                logic p;
                p = 1'($urandom);
                cyc(1'b1, p, p ? ($urandom_range(3) != 0) : 1'($urandom), 8'($urandom));
            end else begin
                cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            end
            reg_r14 = 3'($urandom);
            status_in = 8'($urandom);
        end
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
